dmem_responder: RTL and testbench

Data-side responder for the MEM stage's data-memory port. It is a direct-mapped, write-back, write-allocate cache. It answers MEM-stage word reads and writes, and fills or evicts 256-bit lines over a burst-style physical-memory port. It sits between the MEM stage and the memory arbiter/cacheline adaptor.

---
 rtl/dmem_responder.sv | 158 +++++++++++++++
 tb/tb_dmem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM-stage port.
// Hits complete in the request cycle; misses evict/fill 256-bit lines over pmem.
module dmem_responder #(
  parameter int S_INDEX = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [3:0]   mem_byte_enable,
  input  logic [31:0]  mem_address,
  input  logic [31:0]  mem_wdata,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int SETS  = 1 << S_INDEX;
  localparam int TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t             r_state;
  logic [SETS-1:0]    r_valid;
  logic [SETS-1:0]    r_dirty;
  logic [TAG_W-1:0]   r_tag  [SETS];
  logic [255:0]       r_data [SETS];
  logic [TAG_W-1:0]   r_req_tag;
  logic [S_INDEX-1:0] r_req_index;
  logic [31:0]        r_rdata;
  logic               r_pmem_read;
  logic               r_pmem_write;
  logic [31:0]        r_pmem_address;
  logic [255:0]       r_pmem_wdata;

  logic               w_req;
  logic [S_INDEX-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [2:0]         w_word;
  logic [255:0]       w_line;
  logic [31:0]        w_word_data;
  logic               w_hit;
  logic               w_resp;
  logic               w_victim_dirty;
  logic               w_fill;
  logic               w_unused;

  function automatic logic [31:0] select_word(input logic [255:0] line,
                                              input logic [2:0]   word);
    return line[{word, 5'b00000} +: 32];
  endfunction

  function automatic logic [255:0] merge_word(input logic [255:0] line,
                                              input logic [2:0]   word,
                                              input logic [3:0]   be,
                                              input logic [31:0]  wdata);
    logic [255:0] res;
    res = line;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[int'(word) * 32 + b * 8 +: 8] = wdata[b * 8 +: 8];
    end
    return res;
  endfunction

  assign w_req          = mem_read | mem_write;
  assign w_index        = mem_address[4+S_INDEX:5];
  assign w_tag          = mem_address[31:5+S_INDEX];
  assign w_word         = mem_address[4:2];
  assign w_line         = r_data[w_index];
  assign w_word_data    = select_word(w_line, w_word);
  assign w_hit          = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_victim_dirty = r_valid[w_index] && r_dirty[w_index];
  assign w_fill         = (r_state == ALLOCATE) && pmem_resp;
  assign w_unused       = ^mem_address[1:0];

  // Hits respond combinationally; rdata otherwise holds the last read word.
  assign w_resp       = !rst && (r_state == IDLE) && w_req && w_hit;
  assign mem_resp     = w_resp;
  assign mem_rdata    = (w_resp && !mem_write) ? w_word_data : r_rdata;
  assign pmem_read    = r_pmem_read;
  assign pmem_write   = r_pmem_write;
  assign pmem_address = r_pmem_address;
  assign pmem_wdata   = r_pmem_wdata;

  // Line storage: fills and write-hit merges never coincide (different states).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_fill) begin
        r_data[r_req_index] <= pmem_rdata;
        r_tag[r_req_index]  <= r_req_tag;
      end else if (w_resp && mem_write) begin
        r_data[w_index] <= merge_word(w_line, w_word, mem_byte_enable, mem_wdata);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_valid        <= '0;
      r_dirty        <= '0;
      r_rdata        <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
      r_pmem_address <= '0;
      r_pmem_wdata   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_hit) begin
            if (mem_write) begin
              if (mem_byte_enable != 4'b0000) r_dirty[w_index] <= 1'b1;
            end else begin
              r_rdata <= w_word_data;
            end
          end else if (w_req) begin
            r_req_tag   <= w_tag;
            r_req_index <= w_index;
            if (w_victim_dirty) begin
              r_state        <= WRITEBACK;
              r_pmem_write   <= 1'b1;
              r_pmem_address <= {r_tag[w_index], w_index, 5'b00000};
              r_pmem_wdata   <= w_line;
            end else begin
              r_state        <= ALLOCATE;
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {w_tag, w_index, 5'b00000};
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            r_dirty[r_req_index] <= 1'b0;
            r_pmem_write         <= 1'b0;
            r_pmem_read          <= 1'b1;
            r_pmem_address       <= {r_req_tag, r_req_index, 5'b00000};
            r_state              <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          if (pmem_resp) begin
            r_valid[r_req_index] <= 1'b1;
            r_dirty[r_req_index] <= 1'b0;
            r_pmem_read          <= 1'b0;
            r_state              <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of MEM-stage accesses against a
// backing line memory, plus hand-written reset-mid-fill and idle-hold sequences.
module tb_dmem_responder;

  localparam int PMEM_DELAY = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write;
  logic [3:0]   mem_byte_enable;
  logic [31:0]  mem_address, mem_wdata, mem_rdata;
  logic         mem_resp;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;
  logic         pmem_resp;

  dmem_responder #(.S_INDEX(3)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_rdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_wb;
    int          exp_rd;
    logic [31:0] exp_wb_addr;
    logic [31:0] exp_wb_w1;
    logic [31:0] exp_rd_addr;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs [NV];

  logic [255:0] model [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;
  int n_both  = 0;

  logic [31:0] op_rdata, op_wb_addr, op_wb_w1, op_rd_addr;
  int          op_lat, op_wb, op_rd;

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] addr,
                              input logic [3:0] be, input logic [31:0] wdata,
                              input bit chk, input logic [31:0] exp_rdata,
                              input int lat, input int wb, input int rdn,
                              input logic [31:0] wb_addr, input logic [31:0] wb_w1,
                              input logic [31:0] rd_addr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.be = be; v.wdata = wdata;
    v.chk_rdata = chk; v.exp_rdata = exp_rdata; v.exp_lat = lat;
    v.exp_wb = wb; v.exp_rd = rdn; v.exp_wb_addr = wb_addr;
    v.exp_wb_w1 = wb_w1; v.exp_rd_addr = rd_addr;
    return v;
  endfunction

  // Untouched lines read back as word i = {8'hC0, line_addr[23:0]} + i.
  function automatic logic [255:0] get_line(input logic [31:0] a);
    logic [255:0] l;
    if (model.exists(a)) return model[a];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = {8'hC0, a[23:0]} + 32'(i);
    return l;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One MEM-stage request held until mem_resp, serving pmem with a fixed delay.
  task automatic mem_op(input bit rd, input bit wr, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int wcnt;
    bit done;
    @(negedge clk);
    mem_read = rd; mem_write = wr; mem_address = addr;
    mem_byte_enable = be; mem_wdata = wd;
    op_lat = -1; op_wb = 0; op_rd = 0; wcnt = 0; done = 1'b0;
    op_wb_addr = '0; op_wb_w1 = '0; op_rd_addr = '0; op_rdata = '0;
    for (int c = 0; c < 60 && !done; c++) begin
      #1;
      if (pmem_read && pmem_write) n_both++;
      if (mem_resp) begin
        op_rdata = mem_rdata;
        op_lat   = c;
        done     = 1'b1;
      end else if (pmem_write) begin
        if (wcnt == 0) begin
          op_wb_addr = pmem_address;
          op_wb_w1   = pmem_wdata[63:32];
        end
        wcnt++;
        if (wcnt == PMEM_DELAY) begin
          model[pmem_address] = pmem_wdata;
          pmem_resp = 1'b1;
          op_wb++;
          wcnt = 0;
        end
      end else if (pmem_read) begin
        if (wcnt == 0) op_rd_addr = pmem_address;
        wcnt++;
        if (wcnt == PMEM_DELAY) begin
          pmem_rdata = get_line(pmem_address);
          pmem_resp  = 1'b1;
          op_rd++;
          wcnt = 0;
        end
      end
      @(negedge clk);
      pmem_resp = 1'b0;
    end
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    logic [255:0] l100, l1100;
    bit seen;

    for (int i = 0; i < 8; i++) begin
      l100[i*32 +: 32]  = 32'hA000_0000 + 32'(i);
      l1100[i*32 +: 32] = 32'hB000_0000 + 32'(i);
    end
    l100[63:32] = 32'hDEAD_BEEF;
    model[32'h0000_0100] = l100;
    model[32'h0000_1100] = l1100;

    //          rd wr addr            be       wdata          chk rdata         lat wb rd wb_addr         wb_w1           rd_addr
    vecs[0]  = mk(1, 0, 32'h0000_0104, 4'h0, 32'h0,         1, 32'hDEAD_BEEF, 4, 0, 1, 32'h0,         32'h0,         32'h0000_0100);
    vecs[1]  = mk(1, 0, 32'h0000_0104, 4'h0, 32'h0,         1, 32'hDEAD_BEEF, 0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[2]  = mk(0, 1, 32'h0000_0104, 4'h3, 32'h1122_3344, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[3]  = mk(1, 0, 32'h0000_0104, 4'h0, 32'h0,         1, 32'hDEAD_3344, 0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[4]  = mk(1, 0, 32'h0000_1104, 4'h0, 32'h0,         1, 32'hB000_0001, 7, 1, 1, 32'h0000_0100, 32'hDEAD_3344, 32'h0000_1100);
    vecs[5]  = mk(1, 0, 32'h0000_0108, 4'h0, 32'h0,         1, 32'hA000_0002, 4, 0, 1, 32'h0,         32'h0,         32'h0000_0100);
    vecs[6]  = mk(0, 1, 32'h0000_0120, 4'hF, 32'hCAFE_F00D, 0, 32'h0,         4, 0, 1, 32'h0,         32'h0,         32'h0000_0120);
    vecs[7]  = mk(0, 1, 32'h0000_0124, 4'h8, 32'h7766_5544, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[8]  = mk(1, 0, 32'h0000_0120, 4'h0, 32'h0,         1, 32'hCAFE_F00D, 0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[9]  = mk(1, 0, 32'h0000_0124, 4'h0, 32'h0,         1, 32'h7700_0121, 0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[10] = mk(1, 0, 32'h0000_0320, 4'h0, 32'h0,         1, 32'hC000_0320, 7, 1, 1, 32'h0000_0120, 32'h7700_0121, 32'h0000_0320);
    vecs[11] = mk(1, 0, 32'h0000_0120, 4'h0, 32'h0,         1, 32'hCAFE_F00D, 4, 0, 1, 32'h0,         32'h0,         32'h0000_0120);
    vecs[12] = mk(1, 1, 32'h0000_0124, 4'hF, 32'h0BAD_CAFE, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[13] = mk(1, 0, 32'h0000_0124, 4'h0, 32'h0,         1, 32'h0BAD_CAFE, 0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[14] = mk(0, 1, 32'h0000_01E0, 4'h0, 32'hFFFF_FFFF, 0, 32'h0,         4, 0, 1, 32'h0,         32'h0,         32'h0000_01E0);
    vecs[15] = mk(0, 1, 32'h0000_01E0, 4'h0, 32'hFFFF_FFFF, 0, 32'h0,         0, 0, 0, 32'h0,         32'h0,         32'h0);
    vecs[16] = mk(1, 0, 32'h0000_03E0, 4'h0, 32'h0,         1, 32'hC000_03E0, 4, 0, 1, 32'h0,         32'h0,         32'h0000_03E0);

    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = '0;
    mem_address = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_mem_resp",     32'(mem_resp),     32'h0);
    check("reset_mem_rdata",    mem_rdata,         32'h0);
    check("reset_pmem_read",    32'(pmem_read),    32'h0);
    check("reset_pmem_write",   32'(pmem_write),   32'h0);
    check("reset_pmem_address", pmem_address,      32'h0);
    check("reset_pmem_wdata",   32'(|pmem_wdata),  32'h0);

    for (int i = 0; i < NV; i++) begin
      mem_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata);
      check($sformatf("v%0d_latency", i), 32'(op_lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_writebacks", i), 32'(op_wb), 32'(vecs[i].exp_wb));
      check($sformatf("v%0d_fills", i), 32'(op_rd), 32'(vecs[i].exp_rd));
      if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), op_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_wb > 0) begin
        check($sformatf("v%0d_wb_addr", i), op_wb_addr, vecs[i].exp_wb_addr);
        check($sformatf("v%0d_wb_word1", i), op_wb_w1, vecs[i].exp_wb_w1);
      end
      if (vecs[i].exp_rd > 0) check($sformatf("v%0d_fill_addr", i), op_rd_addr, vecs[i].exp_rd_addr);
    end

    // Request dropped: single pulse, read data held.
    #1;
    check("idle_mem_resp",   32'(mem_resp), 32'h0);
    check("idle_rdata_hold", mem_rdata,     32'hC000_03E0);

    // Reset during ALLOCATE, then a late pmem_resp must be ignored.
    @(negedge clk);
    mem_read = 1'b1; mem_address = 32'h0000_05A4;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (pmem_read) seen = 1'b1;
      else @(negedge clk);
    end
    check("rst_fill_started", 32'(seen), 32'h1);
    rst = 1'b1; mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b0; pmem_resp = 1'b1; pmem_rdata = '1;
    #1;
    check("midrst_mem_resp",     32'(mem_resp),    32'h0);
    check("midrst_mem_rdata",    mem_rdata,        32'h0);
    check("midrst_pmem_read",    32'(pmem_read),   32'h0);
    check("midrst_pmem_write",   32'(pmem_write),  32'h0);
    check("midrst_pmem_address", pmem_address,     32'h0);
    check("midrst_pmem_wdata",   32'(|pmem_wdata), 32'h0);
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    check("late_resp_pmem_read", 32'(pmem_read), 32'h0);
    mem_op(1'b1, 1'b0, 32'h0000_05A4, 4'h0, 32'h0);
    check("post_rst_latency",   32'(op_lat),  32'd4);
    check("post_rst_fills",     32'(op_rd),   32'd1);
    check("post_rst_wbs",       32'(op_wb),   32'd0);
    check("post_rst_fill_addr", op_rd_addr,   32'h0000_05A0);
    check("post_rst_rdata",     op_rdata,     32'hC000_05A1);

    check("pmem_rd_wr_overlap", 32'(n_both), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
